// File: rtl/reg_scoreboard.sv
// Register scoreboard for the in-order RV32I core: per-register pending-write
// counters that hold decode-stage issue until its source registers are clean.
module reg_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int INF_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [29:0]      id_instr,
    output logic             id_ready,
    output logic             issue,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy,
    output logic [INF_W-1:0] inflight,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [CNT_W-1:0] cnt [32];

    logic [4:0] opc, rd, rs1, rs2;
    logic       reads_rs1, reads_rs2, writes_rd;
    logic       use_rs1, use_rs2, wr_en;
    logic       hazard, full;
    logic       inc, dec, wb_err;
    logic       unused_fields;

    assign opc = id_instr[4:0];
    assign rd  = id_instr[9:5];
    assign rs1 = id_instr[17:13];
    assign rs2 = id_instr[22:18];
    assign unused_fields = ^{id_instr[29:23], id_instr[12:10]};

    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        writes_rd = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                reads_rs1 = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
            default: ;
        endcase
    end

    // x0 is never a hazard and never tracked.
    assign use_rs1 = reads_rs1 && (rs1 != 5'd0);
    assign use_rs2 = reads_rs2 && (rs2 != 5'd0);
    assign wr_en   = writes_rd && (rd != 5'd0);

    assign hazard = (use_rs1 && (cnt[rs1] != '0)) || (use_rs2 && (cnt[rs2] != '0));
    assign full   = wr_en && ((cnt[rd] == CNT_MAX) || (inflight == INF_MAX));

    // Handshake: an instruction issues on a cycle where id_valid and id_ready are
    // both high. id_ready never looks at id_valid or at same-cycle writeback.
    assign id_ready = !flush && !hazard && !full;
    assign issue    = id_valid && id_ready;

    assign inc    = issue && wr_en;
    assign dec    = !flush && wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] != '0);
    assign wb_err = !flush && wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            inflight <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                // Issue and retire on one register cancel out.
                if (inc && (rd == 5'(r)) && !(dec && (wb_rd == 5'(r))))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec && (wb_rd == 5'(r)) && !(inc && (rd == 5'(r))))
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (inc && !dec)
                inflight <= inflight + 1'b1;
            else if (dec && !inc)
                inflight <= inflight - 1'b1;
            if (wb_err)
                err <= 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < 32; r++) busy[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic, with a
// reference model feeding an expected-state queue checked after every edge.
module tb_reg_scoreboard;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [29:0] id_instr = '0;
    logic        id_ready, issue;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] busy;
    logic [2:0]  inflight;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [35:0] exp_q [$];
    int  m_cnt [32];
    int  m_inf;
    bit  m_err;
    bit  m_ready;

    reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4), .INF_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_ready(id_ready), .issue(issue), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .busy(busy), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_inf = 0;
        m_err = 1'b0;
    endtask

    // Drive one cycle at the falling edge and push the state expected after the next rising edge.
    task automatic drive(input bit v, input logic [29:0] ins, input bit wv,
                         input logic [4:0] wr, input bit fl);
        bit r1, r2, w, iss, dec_ok;
        int rd, s1, s2;
        logic [31:0] be;
        @(negedge clk);
        id_valid = v; id_instr = ins; wb_valid = wv; wb_rd = wr; flush = fl;
        r1 = 0; r2 = 0; w = 0;
        case (ins[4:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin r1 = 1; w = 1; end
            OPC_OP:                        begin r1 = 1; r2 = 1; w = 1; end
            OPC_STORE, OPC_BRANCH:         begin r1 = 1; r2 = 1; end
            OPC_LUI, OPC_AUIPC, OPC_JAL:   w = 1;
            default: ;
        endcase
        rd = int'(ins[9:5]); s1 = int'(ins[17:13]); s2 = int'(ins[22:18]);
        m_ready = !fl
                  && !(r1 && s1 != 0 && m_cnt[s1] != 0)
                  && !(r2 && s2 != 0 && m_cnt[s2] != 0)
                  && !(w && rd != 0 && (m_cnt[rd] == 3 || m_inf == 4));
        iss = v && m_ready;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_inf = 0;
        end else begin
            dec_ok = wv && wr != 0 && m_cnt[wr] != 0;
            if (wv && wr != 0 && m_cnt[wr] == 0) m_err = 1'b1;
            if (iss && w && rd != 0) begin m_cnt[rd]++; m_inf++; end
            if (dec_ok) begin m_cnt[wr]--; m_inf--; end
        end
        for (int r = 0; r < 32; r++) be[r] = (m_cnt[r] != 0);
        exp_q.push_back({m_err, 3'(m_inf), be});
    endtask

    task automatic idle();
        drive(0, '0, 0, 5'd0, 0);
    endtask

    always @(posedge clk) begin
        logic [35:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({err, inflight, busy} !== e) begin
                errors++;
                $display("FAIL state: got err=%0b inflight=%0d busy=%h, expected err=%0b inflight=%0d busy=%h",
                         err, inflight, busy, e[35], e[34:32], e[31:0]);
            end
        end
    end

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (busy !== 32'h0 || inflight !== 3'd0 || err !== 1'b0 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: busy=%h inflight=%0d err=%0b id_ready=%0b, expected 0/0/0/1",
                     busy, inflight, err, id_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive(1, mk(OPC_OP_IMM, 5'd5, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b1 || issue !== 1'b1) begin
            errors++; $display("FAIL basic_issue: id_ready=%0b issue=%0b, expected 1/1", id_ready, issue);
        end
        drive(1, mk(OPC_OP, 5'd6, 5'd5, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b0 || busy[5] !== 1'b1 || inflight !== 3'd1) begin
            errors++; $display("FAIL basic_hazard: id_ready=%0b busy5=%0b inflight=%0d, expected 0/1/1",
                               id_ready, busy[5], inflight);
        end
        drive(1, mk(OPC_OP, 5'd6, 5'd5, 5'd0), 1, 5'd5, 0);
        #1; checks++;
        if (id_ready !== 1'b0) begin
            errors++; $display("FAIL basic_no_forward: id_ready=%0b, expected 0", id_ready);
        end
        drive(1, mk(OPC_OP, 5'd6, 5'd5, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b1 || busy[5] !== 1'b0 || inflight !== 3'd0) begin
            errors++; $display("FAIL basic_release: id_ready=%0b busy5=%0b inflight=%0d, expected 1/0/0",
                               id_ready, busy[5], inflight);
        end
        drive(0, '0, 0, 5'd0, 1);
    endtask

    task automatic test_x0();
        drive(1, mk(OPC_LUI, 5'd0, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (issue !== 1'b1) begin
            errors++; $display("FAIL x0_lui: issue=%0b, expected 1", issue);
        end
        drive(1, mk(OPC_OP, 5'd0, 5'd0, 5'd0), 1, 5'd0, 0);
        #1; checks++;
        if (issue !== 1'b1) begin
            errors++; $display("FAIL x0_op: issue=%0b, expected 1", issue);
        end
        idle();
        #1; checks++;
        if (busy !== 32'h0 || inflight !== 3'd0 || err !== 1'b0) begin
            errors++; $display("FAIL x0_state: busy=%h inflight=%0d err=%0b, expected 0/0/0", busy, inflight, err);
        end
    endtask

    task automatic test_inflight();
        for (int i = 1; i <= 4; i++) begin
            drive(1, mk(OPC_OP_IMM, 5'(i), 5'd0, 5'd0), 0, 5'd0, 0);
            #1; checks++;
            if (issue !== 1'b1) begin
                errors++; $display("FAIL inflight_fill%0d: issue=%0b, expected 1", i, issue);
            end
        end
        drive(1, mk(OPC_OP_IMM, 5'd6, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (inflight !== 3'd4 || id_ready !== 1'b0) begin
            errors++; $display("FAIL inflight_full: inflight=%0d id_ready=%0b, expected 4/0", inflight, id_ready);
        end
        drive(1, mk(OPC_STORE, 5'd0, 5'd7, 5'd8), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL inflight_store: id_ready=%0b, expected 1", id_ready);
        end
        drive(0, '0, 0, 5'd0, 1);
    endtask

    task automatic test_cnt_sat();
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 0, 5'd0, 0);
            #1; checks++;
            if (issue !== 1'b1) begin
                errors++; $display("FAIL sat_fill%0d: issue=%0b, expected 1", i, issue);
            end
        end
        drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b0 || inflight !== 3'd3) begin
            errors++; $display("FAIL sat_block: id_ready=%0b inflight=%0d, expected 0/3", id_ready, inflight);
        end
        drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 1, 5'd9, 0);
        #1; checks++;
        if (id_ready !== 1'b0) begin
            errors++; $display("FAIL sat_block_wb: id_ready=%0b, expected 0", id_ready);
        end
        drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 1, 5'd9, 0);
        #1; checks++;
        if (id_ready !== 1'b1 || inflight !== 3'd2) begin
            errors++; $display("FAIL sat_issue_wb: id_ready=%0b inflight=%0d, expected 1/2", id_ready, inflight);
        end
        drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b1 || inflight !== 3'd2 || busy[9] !== 1'b1) begin
            errors++; $display("FAIL sat_cancel: id_ready=%0b inflight=%0d busy9=%0b, expected 1/2/1",
                               id_ready, inflight, busy[9]);
        end
        drive(1, mk(OPC_LUI, 5'd9, 5'd0, 5'd0), 0, 5'd0, 0);
        #1; checks++;
        if (id_ready !== 1'b0 || inflight !== 3'd3) begin
            errors++; $display("FAIL sat_refull: id_ready=%0b inflight=%0d, expected 0/3", id_ready, inflight);
        end
        drive(0, '0, 0, 5'd0, 1);
    endtask

    task automatic test_flush();
        drive(1, mk(OPC_OP_IMM, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0);
        drive(1, mk(OPC_OP_IMM, 5'd4, 5'd0, 5'd0), 0, 5'd0, 0);
        drive(1, mk(OPC_OP_IMM, 5'd7, 5'd0, 5'd0), 1, 5'd3, 1);
        #1; checks++;
        if (id_ready !== 1'b0 || issue !== 1'b0 || busy[4:3] !== 2'b11) begin
            errors++; $display("FAIL flush_block: id_ready=%0b issue=%0b busy=%h, expected 0/0/x3,x4 busy",
                               id_ready, issue, busy);
        end
        idle();
        #1; checks++;
        if (busy !== 32'h0 || inflight !== 3'd0 || err !== 1'b0) begin
            errors++; $display("FAIL flush_clear: busy=%h inflight=%0d err=%0b, expected 0/0/0", busy, inflight, err);
        end
    endtask

    task automatic test_err();
        drive(0, '0, 1, 5'd12, 0);
        idle();
        #1; checks++;
        if (err !== 1'b1 || inflight !== 3'd0) begin
            errors++; $display("FAIL err_set: err=%0b inflight=%0d, expected 1/0", err, inflight);
        end
        drive(1, mk(OPC_OP_IMM, 5'd2, 5'd0, 5'd0), 0, 5'd0, 0);
        drive(0, '0, 1, 5'd2, 0);
        idle();
        #1; checks++;
        if (err !== 1'b1 || inflight !== 3'd0) begin
            errors++; $display("FAIL err_sticky: err=%0b inflight=%0d, expected 1/0", err, inflight);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1; checks++;
        if (err !== 1'b0 || busy !== 32'h0 || inflight !== 3'd0) begin
            errors++; $display("FAIL err_async_reset: err=%0b busy=%h inflight=%0d, expected 0/0/0", err, busy, inflight);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] ops [10];
        logic [4:0] op;
        ops = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 9)];
            drive(bit'($urandom_range(0, 1)),
                  mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                  bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0));
            #1; checks++;
            if (id_ready !== m_ready) begin
                errors++; $display("FAIL random_ready[%0d]: id_ready=%0b, expected %0b", i, id_ready, m_ready);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_inflight();
        test_cnt_sat();
        test_flush();
        test_err();
        test_random();
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL drain: %0d expected states left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
